// File: rtl/comb_truth_table_scanner.sv
// comb_truth_table_scanner
// Stimulus/response stage wrapped around an external 3-input combinational
// function. One scan walks {A,B,C} through 0..7 in ascending order, holds each
// vector for SETTLE_CYCLES clocks, captures Y on the last of those clocks into
// table_out, and then compares the finished table against a golden minterm
// mask. The scan ends with a one-cycle done pulse, a registered pass flag and a
// per-minterm mismatch map.
//
// Handshake: start is a level-sampled request. It is accepted on any rising
// edge where the FSM is in IDLE and start is high. While a scan is running
// (SETTLE or DONE), start is ignored. busy is high from the accepting edge
// until DONE is left. done is high for exactly one cycle, and table_out, pass
// and mismatch are valid in that cycle. Those three outputs then hold until the
// next accepted start (table_out clears at the start; pass and mismatch update
// at that scan's DONE).
//
// Y comes from the same clock domain and must be stable by the sampling edge.
// No synchronizer is added.

module comb_truth_table_scanner #(
    parameter int         SETTLE_CYCLES = 2,     // 1..15 clocks per vector
    parameter logic [7:0] EXPECTED      = 8'hB4  // bit i = golden Y for vector i
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
    output logic [7:0] mismatch
);

    // ------------------------------------------------------------------
    // State encoding. The state register is a plain named signal so that
    // checkers can bind to it directly.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Settle counter value on which Y is captured for the current vector.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    // Index of the last vector in the scan.
    localparam logic [2:0] IDX_LAST = 3'd7;

    // ------------------------------------------------------------------
    // Registered state and datapath
    // ------------------------------------------------------------------
    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [2:0] abc;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [7:0] table_q;
    logic [7:0] mismatch_q;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t     state_d;
    logic [2:0] idx_d;
    logic [3:0] cnt_d;
    logic [2:0] abc_d;
    logic       busy_d;
    logic       done_d;
    logic       pass_d;
    logic [7:0] table_d;
    logic [7:0] mismatch_d;

    // The capture strobe and the table with the current sample merged in.
    // The merged table feeds the final compare, so pass and mismatch see
    // the bit for vector 7 in the same edge that captures it.
    logic       capture;
    logic [7:0] table_cap;

    // Capture strobe and the table as it will look after this edge's sample.
    always_comb begin
        capture        = (state == S_SETTLE) && (cnt == CNT_LAST);
        table_cap      = table_q;
        table_cap[idx] = Y;
    end

    // Next-state logic and the values for every registered output.
    always_comb begin
        // Default: hold everything. done is a pulse, so it defaults low.
        state_d    = state;
        idx_d      = idx;
        cnt_d      = cnt;
        abc_d      = abc;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        table_d    = table_q;
        mismatch_d = mismatch_q;

        case (state)
            S_IDLE: begin
                abc_d  = 3'b000;
                busy_d = 1'b0;
                if (start) begin
                    // Accept the request. The previous table is cleared now.
                    // pass and mismatch keep the last result until this
                    // scan finishes.
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    abc_d   = 3'b000;
                    table_d = 8'h00;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                busy_d = 1'b1;
                if (capture) begin
                    table_d = table_cap;
                    cnt_d   = 4'd0;
                    if (idx == IDX_LAST) begin
                        // Last vector captured. Hold {A,B,C} at 7 for the
                        // DONE cycle and register the verdict on the final
                        // table.
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        pass_d     = (table_cap == EXPECTED);
                        mismatch_d = table_cap ^ EXPECTED;
                    end else begin
                        idx_d = idx + 3'd1;
                        abc_d = idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end

            S_DONE: begin
                // Single-cycle results window. Leaving it drops busy and
                // returns the stimulus to 000.
                busy_d  = 1'b0;
                abc_d   = 3'b000;
                state_d = S_IDLE;
            end

            default: begin
                // Unused encoding: recover to a clean idle.
                state_d = S_IDLE;
                idx_d   = 3'd0;
                cnt_d   = 4'd0;
                abc_d   = 3'b000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with asynchronous reset. Reset aborts a scan mid-flight
    // without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and output registers. Reset clears the previous result as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 3'd0;
            cnt        <= 4'd0;
            abc        <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            table_q    <= 8'h00;
            mismatch_q <= 8'h00;
        end else begin
            idx        <= idx_d;
            cnt        <= cnt_d;
            abc        <= abc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            table_q    <= table_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Every output comes straight from a register.
    assign A         = abc[2];
    assign B         = abc[1];
    assign C         = abc[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign table_out = table_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_comb_truth_table_scanner.sv
// Directed bench for comb_truth_table_scanner. It uses two instances: one at
// the default settle time, driven by a selectable model of the combinational
// stage, and one with SETTLE_CYCLES=1 driven by a model with a stuck-0 fault on
// minterm 5. The bench samples outputs on the falling clock edge and drives
// inputs there as well.

module tb_comb_truth_table_scanner;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT 0: SETTLE_CYCLES = 2 ----------------
    logic       start0;
    logic       a0, b0, c0, y0, busy0, done0, pass0;
    logic [7:0] tab0, mm0;
    int         ymode;  // 0 golden, 1 tied 0, 2 tied 1

    // Reference combinational stage. Minterms 2,4,5,7 are written out by hand.
    function automatic logic golden(input logic a, input logic b, input logic c);
        return (~a & b & ~c) | (a & ~b) | (a & b & c);
    endfunction

    assign y0 = (ymode == 1) ? 1'b0 :
                (ymode == 2) ? 1'b1 : golden(a0, b0, c0);

    comb_truth_table_scanner #(.SETTLE_CYCLES(2), .EXPECTED(8'hB4)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .A(a0), .B(b0), .C(c0), .Y(y0),
        .busy(busy0), .done(done0), .pass(pass0),
        .table_out(tab0), .mismatch(mm0)
    );

    // ---------------- DUT 1: SETTLE_CYCLES = 1, minterm 5 stuck-0 ----------------
    logic       start1;
    logic       a1, b1, c1, y1, busy1, done1, pass1;
    logic [7:0] tab1, mm1;

    assign y1 = golden(a1, b1, c1) & ~({a1, b1, c1} == 3'd5);

    comb_truth_table_scanner #(.SETTLE_CYCLES(1), .EXPECTED(8'hB4)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .A(a1), .B(b1), .C(c1), .Y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .table_out(tab1), .mismatch(mm1)
    );

    // ---------------- scoreboard ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One scan on DUT 0 from a single start pulse. The loop samples after
    // edges 0..17 (edge 0 is the accepting edge). If retrig >= 0, start is
    // pulsed again so that it is sampled on edge retrig+1.
    task automatic scan0(input string name, input logic [7:0] et, input logic [7:0] em,
                         input logic ep, input logic pp, input int retrig);
        logic [2:0] ea;
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (k == 0) start0 = 1'b0;
            if (k == retrig) start0 = 1'b1;
            if (k == retrig + 1 && retrig >= 0) start0 = 1'b0;
            ea = (k < 16) ? 3'(k / 2) : ((k == 16) ? 3'd7 : 3'd0);
            check({name, "_abc"},  8'({a0, b0, c0}), 8'(ea));
            check({name, "_done"}, 8'(done0), 8'(k == 16));
            check({name, "_busy"}, 8'(busy0), 8'(k <= 16));
            if (k == 0) begin
                check({name, "_tab_clr"},   tab0, 8'h00);
                check({name, "_pass_hold"}, 8'(pass0), 8'(pp));
            end
            if (k == 16) begin
                check({name, "_table"},    tab0, et);
                check({name, "_mismatch"}, mm0, em);
                check({name, "_pass"},     8'(pass0), 8'(ep));
            end
        end
    endtask

    // Watchdog: the run is a few hundred cycles, so this only fires on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] ea;
        start0 = 1'b0;
        start1 = 1'b0;
        ymode  = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_abc",  8'({a0, b0, c0}), 8'h00);
        check("rst_busy", 8'(busy0), 8'h00);
        check("rst_done", 8'(done0), 8'h00);
        check("rst_pass", 8'(pass0), 8'h00);
        check("rst_tab",  tab0, 8'h00);
        check("rst_mm",   mm0, 8'h00);
        rst = 1'b0;

        // 1: golden scan
        scan0("golden", 8'hB4, 8'h00, 1'b1, 1'b0, -1);

        // 3: start re-pulsed at edge 5 while busy is ignored
        scan0("retrig", 8'hB4, 8'h00, 1'b1, 1'b1, 4);

        // 4: asynchronous reset in the middle of cycle 7
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k == 0) start0 = 1'b0;
        end
        check("abort_pre_abc", 8'({a0, b0, c0}), 8'h03);
        check("abort_pre_tab", tab0, 8'h04);
        #2 rst = 1'b1;
        #1;
        check("abort_abc",  8'({a0, b0, c0}), 8'h00);
        check("abort_busy", 8'(busy0), 8'h00);
        check("abort_pass", 8'(pass0), 8'h00);
        check("abort_tab",  tab0, 8'h00);
        check("abort_done", 8'(done0), 8'h00);
        @(negedge clk);
        check("abort_done2", 8'(done0), 8'h00);
        rst = 1'b0;
        scan0("post_abort", 8'hB4, 8'h00, 1'b1, 1'b0, -1);

        // 2: Y tied low and Y tied high
        ymode = 1;
        scan0("tie0", 8'h00, 8'hB4, 1'b0, 1'b1, -1);
        ymode = 2;
        scan0("tie1", 8'hFF, 8'h4B, 1'b0, 1'b0, -1);
        ymode = 0;

        // 5: start held high gives back-to-back scans with one idle cycle
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 0; k <= 35; k++) begin
            @(negedge clk);
            if (k == 34) start0 = 1'b0;
            if (k < 16)       ea = 3'(k / 2);
            else if (k == 16) ea = 3'd7;
            else if (k == 17) ea = 3'd0;
            else if (k < 34)  ea = 3'((k - 18) / 2);
            else if (k == 34) ea = 3'd7;
            else              ea = 3'd0;
            check("b2b_abc",  8'({a0, b0, c0}), 8'(ea));
            check("b2b_done", 8'(done0), 8'(k == 16 || k == 34));
            check("b2b_busy", 8'(busy0), 8'(k != 17 && k != 35));
        end
        check("b2b_pass", 8'(pass0), 8'h01);

        // 6: SETTLE_CYCLES=1 instance with a stuck-0 fault on minterm 5
        @(negedge clk);
        start1 = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 0) start1 = 1'b0;
            ea = (k < 8) ? 3'(k) : ((k == 8) ? 3'd7 : 3'd0);
            check("s1_abc",  8'({a1, b1, c1}), 8'(ea));
            check("s1_done", 8'(done1), 8'(k == 8));
            check("s1_busy", 8'(busy1), 8'(k <= 8));
            if (k == 8) begin
                check("s1_table",    tab1, 8'h94);
                check("s1_mismatch", mm1, 8'h20);
                check("s1_pass",     8'(pass1), 8'h00);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
